ddr_axi_slave_responder: RTL and testbench
==========================================

Name: ddr_axi_slave_responder

Overview:
AXI4 slave that answers the AR/R and AW/W/B channels driven by the DDR memory-interface AXI master, backed by an internal word-addressed memory array.
Used as the DDR-side responder in block-level benches and in FPGA loopback builds, in place of the platform memory controller.
It supports INCR bursts of 1–256 beats, byte strobes, and a small queue of outstanding read requests.
It flags write-burst framing errors.

Parameters:
C_M_AXI_ADDR_WIDTH, 64, AXI address width
C_M_AXI_DATA_WIDTH, 512, AXI data width; bytes per word = C_M_AXI_DATA_WIDTH/8
MEM_DEPTH_WORDS, 4096, memory words; power of two
RD_QUEUE_DEPTH, 4, outstanding AR requests held; power of two, at least 2

Ports:
clk  in  1  single clock
reset_n  in  1  asynchronous, active-low reset
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_awaddr  in  C_M_AXI_ADDR_WIDTH  byte address
s_axi_awlen  in  8  beats minus 1
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_wdata  in  C_M_AXI_DATA_WIDTH  write data
s_axi_wstrb  in  C_M_AXI_DATA_WIDTH/8  byte enables
s_axi_wlast  in  1  last write beat
s_axi_bvalid  out  1  write response valid (always OKAY)
s_axi_bready  in  1  write response ready
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_araddr  in  C_M_AXI_ADDR_WIDTH  byte address
s_axi_arlen  in  8  beats minus 1
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
s_axi_rdata  out  C_M_AXI_DATA_WIDTH  read data
s_axi_rlast  out  1  last read beat
err_wlast  out  1  sticky framing-error flag

Behaviour:
- Reset (reset_n low, asynchronous):
  - All outputs go to 0, including rdata and err_wlast.
  - Both FSMs return to IDLE and the AR queue is emptied.
  - Memory contents are not cleared.
  - Reset mid-burst abandons the burst with no B or R completion.
- Address mapping: word index = addr[LP_ADDR_LSB +: log2(MEM_DEPTH_WORDS)]. Upper bits are ignored and the index wraps modulo depth, including inside a burst.
- Write FSM states and transitions:
  - W_IDLE: awready=1. On AW handshake, latch the index and awlen, clear the beat counter, and go to W_DATA.
  - W_DATA: wready=1. On each W handshake, write the bytes whose wstrb bit is set, then increment the index and counter.
  - On the beat where counter==awlen, go to W_RESP.
  - err_wlast is set if wlast != (counter==awlen) on any beat. The burst length always follows awlen, never wlast.
  - W_RESP: bvalid=1, held until bready, then W_IDLE. bvalid first rises the cycle after the final W handshake.
- Write flow control: awready=0 outside W_IDLE, so at most one write is outstanding.
- Read queue:
  - arready = !queue_full, combinational from registered occupancy.
  - An AR handshake pushes {index, arlen}.
  - A simultaneous push and pop is allowed when the queue is full.
- Read FSM states and transitions:
  - R_IDLE: if the queue is non-empty, pop into ptr/len and go to R_FETCH.
  - R_FETCH: rdata <= mem[ptr], go to R_DATA.
  - R_DATA: rvalid=1 and rlast=(counter==len). rdata, rvalid and rlast stay stable while rready=0.
  - On a non-last R handshake: ptr+1, counter+1, rdata <= mem[ptr+1] on the same edge. This gives one beat per cycle.
  - On the last handshake: go to R_IDLE.
- Read latency: first rvalid appears 3 cycles after the AR handshake when the read path is idle. There is a 2-cycle bubble between consecutive read bursts.
- Read/write collision: a read and a write to the same word on the same edge returns the old data (read-first).
- The read and write paths run fully independently.
- err_wlast is cleared only by reset.

Decomposition:
- Package ddr_axi_slave_responder_pkg holds:
  - the write-state enum {W_IDLE, W_DATA, W_RESP};
  - the read-state enum {R_IDLE, R_FETCH, R_DATA};
  - LP_ADDR_LSB = $clog2(C_M_AXI_DATA_WIDTH/8);
  - the AR queue entry struct {index, len}.
- One sub-module: ddr_axi_slave_responder_ar_fifo, a synchronous FIFO with depth RD_QUEUE_DEPTH, full/empty outputs, and reset_n.

Test Plan:
- Single-beat round trip: AW 0x40 with awlen=0, W wdata=pattern A, wstrb all ones, wlast=1 -> bvalid one cycle after the W handshake. Then AR 0x40 with arlen=0 -> rdata=A and rlast=1, with rvalid exactly 3 cycles after the AR handshake.
- 16-beat burst: write 16 beats of incrementing data at 0x1000, then read 16 beats with rready toggling 1/0 -> beats return in order, rdata is held while rready=0, and rlast is set only on beat 16.
- Partial strobe: preload word 0 with all 0xFF, then write 0x00 with wstrb=0x...000F -> readback has bytes 0–3 = 0x00 and all other bytes = 0xFF.
- Framing error: awlen=3 with wlast asserted on beat 2 -> err_wlast=1, and bvalid rises only after the 4th W handshake.
- Queue full and wrap: 5 ARs presented back-to-back with rready=0 and RD_QUEUE_DEPTH=4 -> arready drops after the 4th AR. A burst at index MEM_DEPTH_WORDS-1 with arlen=1 returns mem[last], then mem[0].
- Reset mid-burst: drop reset_n during beat 5 of an 8-beat read -> rvalid=0 immediately, and both FSMs are idle after release. Data written before the reset reads back unchanged.

Source files
------------

// File: rtl/ddr_axi_slave_responder_pkg.sv
// Shared types and constants for the DDR-side AXI4 slave responder.
package ddr_axi_slave_responder_pkg;

  // Default data width and the matching byte-offset width inside a word.
  localparam int LP_DEF_DATA_WIDTH = 512;
  localparam int LP_ADDR_LSB       = $clog2(LP_DEF_DATA_WIDTH / 8);

  // Read-queue entries carry a generously sized index; the top uses the low bits.
  localparam int LP_IDX_MAX_W = 32;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } r_state_e;

  typedef struct packed {
    logic [LP_IDX_MAX_W-1:0] index;
    logic [7:0]              len;
  } ar_entry_t;

  // Byte-offset width for an arbitrary data width.
  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/ddr_axi_slave_responder_ar_fifo.sv
// Small synchronous FIFO holding outstanding AR requests (first-word fall-through).
module ddr_axi_slave_responder_ar_fifo
  import ddr_axi_slave_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      push_i,
  input  ar_entry_t din_i,
  input  logic      pop_i,
  output ar_entry_t dout_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  ar_entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W:0]     count_q;
  logic               do_push_s;
  logic               do_pop_s;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
  assign do_pop_s  = pop_i && !empty_o;
  // A pop frees a slot on the same edge, so a full queue may still accept a push.
  assign do_push_s = push_i && (!full_o || do_pop_s);
  assign dout_o    = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ddr_axi_slave_responder.sv
// AXI4 slave with an internal word memory: INCR bursts, byte strobes, queued reads.
module ddr_axi_slave_responder
  import ddr_axi_slave_responder_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int MEM_DEPTH_WORDS    = 4096,
  parameter int RD_QUEUE_DEPTH     = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                            s_axi_rlast,
  output logic                            err_wlast
);

  localparam int ADDR_LSB = addr_lsb(C_M_AXI_DATA_WIDTH);
  localparam int IDX_W    = $clog2(MEM_DEPTH_WORDS);
  localparam int NBYTES   = C_M_AXI_DATA_WIDTH / 8;

  typedef logic [C_M_AXI_DATA_WIDTH-1:0] word_t;

  word_t mem_q [MEM_DEPTH_WORDS];

  // Held low through reset so the ready outputs read 0 while reset_n is low.
  logic       live_q;

  w_state_e   w_state_q, w_state_d;
  logic [IDX_W-1:0] w_idx_q;
  logic [7:0] w_len_q, w_cnt_q;
  logic       err_wlast_q;

  r_state_e   r_state_q, r_state_d;
  logic [IDX_W-1:0] r_ptr_q;
  logic [7:0] r_len_q, r_cnt_q;
  word_t      rdata_q;

  logic       aw_hs_s, w_hs_s, ar_hs_s, r_hs_s;
  logic       w_last_beat_s, r_last_beat_s;
  logic       fifo_full_s, fifo_empty_s, fifo_pop_s;
  ar_entry_t  fifo_din_s, fifo_dout_s;
  logic       unused_s;

  assign aw_hs_s       = s_axi_awvalid && s_axi_awready;
  assign w_hs_s        = s_axi_wvalid && s_axi_wready;
  assign ar_hs_s       = s_axi_arvalid && s_axi_arready;
  assign r_hs_s        = s_axi_rvalid && s_axi_rready;
  assign w_last_beat_s = (w_cnt_q == w_len_q);
  assign r_last_beat_s = (r_cnt_q == r_len_q);

  assign s_axi_arready = live_q && !fifo_full_s;
  assign s_axi_rdata   = rdata_q;
  assign err_wlast     = err_wlast_q;
  // Address bits above the word index are intentionally ignored.
  assign unused_s      = ^{s_axi_awaddr, s_axi_araddr, fifo_dout_s.index};

  assign fifo_din_s.index = LP_IDX_MAX_W'(s_axi_araddr[ADDR_LSB +: IDX_W]);
  assign fifo_din_s.len   = s_axi_arlen;
  assign fifo_pop_s       = (r_state_q == R_IDLE) && !fifo_empty_s;

  ddr_axi_slave_responder_ar_fifo #(.DEPTH(RD_QUEUE_DEPTH)) u_ar_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (ar_hs_s),
    .din_i   (fifo_din_s),
    .pop_i   (fifo_pop_s),
    .dout_o  (fifo_dout_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Becomes 1 on the first clock after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) live_q <= 1'b0;
    else          live_q <= 1'b1;
  end

  // Write FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) w_state_q <= W_IDLE;
    else          w_state_q <= w_state_d;
  end

  // Write FSM next state; burst length follows awlen regardless of wlast.
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs_s) w_state_d = W_DATA; else w_state_d = W_IDLE;
      W_DATA:  if (w_hs_s && w_last_beat_s) w_state_d = W_RESP; else w_state_d = W_DATA;
      W_RESP:  if (s_axi_bready) w_state_d = W_IDLE; else w_state_d = W_RESP;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM outputs.
  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (w_state_q)
      W_IDLE:  s_axi_awready = live_q;
      W_DATA:  s_axi_wready  = 1'b1;
      W_RESP:  s_axi_bvalid  = 1'b1;
      default: s_axi_awready = 1'b0;
    endcase
  end

  // Write burst index/counter tracking and sticky wlast framing check.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_idx_q     <= '0;
      w_len_q     <= 8'd0;
      w_cnt_q     <= 8'd0;
      err_wlast_q <= 1'b0;
    end else if (aw_hs_s) begin
      w_idx_q <= s_axi_awaddr[ADDR_LSB +: IDX_W];
      w_len_q <= s_axi_awlen;
      w_cnt_q <= 8'd0;
    end else if (w_hs_s) begin
      w_idx_q <= w_idx_q + IDX_W'(1);
      w_cnt_q <= w_cnt_q + 8'd1;
      if (s_axi_wlast != w_last_beat_s) err_wlast_q <= 1'b1;
    end
  end

  // Byte-masked memory write; contents survive reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NBYTES; b++) begin
      if (w_hs_s && s_axi_wstrb[b]) mem_q[w_idx_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state_q <= R_IDLE;
    else          r_state_q <= r_state_d;
  end

  // Read FSM next state.
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (!fifo_empty_s) r_state_d = R_FETCH; else r_state_d = R_IDLE;
      R_FETCH: r_state_d = R_DATA;
      R_DATA:  if (r_hs_s && r_last_beat_s) r_state_d = R_IDLE; else r_state_d = R_DATA;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read FSM outputs.
  always_comb begin
    s_axi_rvalid = 1'b0;
    s_axi_rlast  = 1'b0;
    case (r_state_q)
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        s_axi_rlast  = r_last_beat_s;
      end
      default: s_axi_rvalid = 1'b0;
    endcase
  end

  // Read datapath: prefetch the next word on each accepted beat for one beat per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr_q <= '0;
      r_len_q <= 8'd0;
      r_cnt_q <= 8'd0;
      rdata_q <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (fifo_pop_s) begin
            r_ptr_q <= fifo_dout_s.index[IDX_W-1:0];
            r_len_q <= fifo_dout_s.len;
            r_cnt_q <= 8'd0;
          end
        end
        R_FETCH: rdata_q <= mem_q[r_ptr_q];
        R_DATA: begin
          if (r_hs_s && !r_last_beat_s) begin
            r_ptr_q <= r_ptr_q + IDX_W'(1);
            r_cnt_q <= r_cnt_q + 8'd1;
            rdata_q <= mem_q[r_ptr_q + IDX_W'(1)];
          end
        end
        default: rdata_q <= rdata_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_axi_slave_responder.sv
// Directed scoreboard bench for ddr_axi_slave_responder.
module tb_ddr_axi_slave_responder;

  localparam int DW    = 512;
  localparam int AW    = 64;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 4096;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, rlast, err_wlast;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [DW-1:0] wdata, rdata;
  logic [NB-1:0] wstrb;

  ddr_axi_slave_responder #(
    .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW),
    .MEM_DEPTH_WORDS(DEPTH), .RD_QUEUE_DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wlast(wlast), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rlast(rlast),
    .err_wlast(err_wlast)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [DEPTH];
  int            total = 0;
  int            bad   = 0;

  function automatic logic [11:0] widx(input logic [AW-1:0] a);
    return a[17:6];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One full write transaction; wlast is raised on beat last_beat (0-based).
  task automatic do_write(input logic [AW-1:0] a, input int len, input logic [DW-1:0] d0,
                          input logic [NB-1:0] strb, input int last_beat);
    int n;
    logic [11:0] i;
    logic [DW-1:0] d;
    i = widx(a);
    awvalid = 1'b1; awaddr = a; awlen = 8'(len);
    n = 0;
    while (!awready && n < 50) begin tick(); n++; end
    chk("awready_wait", awready, 1'b1);
    tick();
    awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      d = d0 + DW'(b);
      wvalid = 1'b1; wdata = d; wstrb = strb; wlast = (b == last_beat);
      n = 0;
      while (!wready && n < 50) begin tick(); n++; end
      chk("wready_wait", wready, 1'b1);
      tick();
      for (int k = 0; k < NB; k++) if (strb[k]) model[i][k*8 +: 8] = d[k*8 +: 8];
      i = i + 12'd1;
      if (b < len) chk("bvalid_early", bvalid, 1'b0);
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid_rise", bvalid, 1'b1);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bvalid_clear", bvalid, 1'b0);
  endtask

  // Queue expected beats and raise arvalid without waiting for acceptance.
  task automatic present_ar(input logic [AW-1:0] a, input int len);
    logic [11:0] i;
    exp_t e;
    i = widx(a);
    for (int b = 0; b <= len; b++) begin
      e.d = model[i];
      e.l = (b == len);
      sb.push_back(e);
      i = i + 12'd1;
    end
    arvalid = 1'b1; araddr = a; arlen = 8'(len);
  endtask

  task automatic do_ar(input logic [AW-1:0] a, input int len);
    int n;
    present_ar(a, len);
    n = 0;
    while (!arready && n < 50) begin tick(); n++; end
    chk("arready_wait", arready, 1'b1);
    tick();
    arvalid = 1'b0;
  endtask

  // Drain nbeats R beats against the scoreboard; also completes a pending AR.
  task automatic collect(input int nbeats, input bit toggle);
    int got, cyc;
    bit ph, ar_fire;
    exp_t e;
    got = 0; cyc = 0; ph = 1'b0;
    while (got < nbeats && cyc < 500) begin
      rready = toggle ? ph : 1'b1;
      ph = !ph;
      if (rvalid) begin
        chk("sb_nonempty", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
          e = sb[0];
          chk("rdata", rdata, e.d);
          chk("rlast", rlast, e.l);
          if (rready) begin
            void'(sb.pop_front());
            got++;
          end
        end
      end
      ar_fire = arvalid && arready;
      tick();
      if (ar_fire) arvalid = 1'b0;
      cyc++;
    end
    rready = 1'b0;
    chk("beats_received", got, nbeats);
  endtask

  initial begin
    int n;
    awvalid = 1'b0; awaddr = '0; awlen = 8'd0; wvalid = 1'b0; wdata = '0; wstrb = '0;
    wlast = 1'b0; bready = 1'b0; arvalid = 1'b0; araddr = '0; arlen = 8'd0; rready = 1'b0;
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rlast", rlast, 1'b0);
    chk("rst_rdata", rdata, '0);
    chk("rst_err", err_wlast, 1'b0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_awready", awready, 1'b1);
    chk("post_rst_arready", arready, 1'b1);

    // Single-beat round trip with latency check.
    do_write(64'h40, 0, {8{64'hDEAD_BEEF_0123_4567}}, {NB{1'b1}}, 0);
    do_ar(64'h40, 0);
    chk("lat_c1", rvalid, 1'b0);
    tick();
    chk("lat_c2", rvalid, 1'b0);
    tick();
    chk("lat_c3", rvalid, 1'b1);
    collect(1, 1'b0);

    // 16-beat burst, read back with rready toggling.
    do_write(64'h1000, 15, {16{32'h1000_0000}}, {NB{1'b1}}, 15);
    do_ar(64'h1000, 15);
    collect(16, 1'b1);

    // Partial strobe over an all-ones word.
    do_write(64'h0, 0, {DW{1'b1}}, {NB{1'b1}}, 0);
    do_write(64'h0, 0, {DW{1'b0}}, 64'h0000_0000_0000_000F, 0);
    do_ar(64'h0, 0);
    collect(1, 1'b0);
    chk("err_clean", err_wlast, 1'b0);

    // Framing error: wlast on beat 2 of 4.
    do_write(64'h2000, 3, {16{32'h2222_0000}}, {NB{1'b1}}, 1);
    chk("err_set", err_wlast, 1'b1);

    // Index wrap, then queue fill behind a stalled burst.
    do_write(64'h3FFC0, 1, {16{32'h3333_0000}}, {NB{1'b1}}, 1);
    do_ar(64'h8000_0000_0003_FFC0, 1);
    n = 0;
    while (!rvalid && n < 10) begin tick(); n++; end
    chk("stall_rvalid", rvalid, 1'b1);
    for (int k = 0; k < 4; k++) begin
      do_ar(64'h1000 + AW'(k * 64), 0);
      chk("arready_fill", arready, (k < 3));
    end
    present_ar(64'h1100, 0);
    tick();
    chk("arready_full_hold", arready, 1'b0);
    collect(7, 1'b0);
    chk("err_sticky", err_wlast, 1'b1);

    // Reset during beat 5 of an 8-beat read.
    do_write(64'h3200, 7, {16{32'h5555_0000}}, {NB{1'b1}}, 7);
    do_ar(64'h3200, 7);
    collect(4, 1'b0);
    chk("beat5_valid", rvalid, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("midrst_rvalid", rvalid, 1'b0);
    chk("midrst_rdata", rdata, '0);
    chk("midrst_rlast", rlast, 1'b0);
    sb.delete();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("rel_awready", awready, 1'b1);
    chk("rel_arready", arready, 1'b1);
    chk("rel_bvalid", bvalid, 1'b0);
    chk("rel_rvalid", rvalid, 1'b0);
    chk("rel_err", err_wlast, 1'b0);
    do_ar(64'h3200, 7);
    collect(8, 1'b1);
    do_ar(64'h40, 0);
    collect(1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
